// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop synchronizer, per-bit glitch filter, registered
// level with rise/fall pulses, and a one-shot capture of the two boot straps.
module gpio_in_cond #(
  parameter int Width        = 32,
  parameter int FilterCycles = 16,
  parameter int StrapLsb     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] cio_gpio_p2d_i,
  input  logic [Width-1:0] filter_en_i,
  output logic [Width-1:0] data_in_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [1:0]       strap_o,
  output logic             strap_valid_o
);

  localparam int CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic [Width-1:0] sync1_q, sync2_q;
  logic [Width-1:0] cand_q, cand_d;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];
  logic [Width-1:0] qual;
  logic [Width-1:0] data_q, data_d;
  logic [Width-1:0] prev_q;
  logic [1:0]       boot_cnt_q;
  logic [1:0]       strap_q;
  logic             strap_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cio_gpio_p2d_i;
      sync2_q <= sync1_q;
    end
  end

  // The filter runs regardless of enable so re-enabling on a stable input adds no delay.
  // Qualification looks at the updated count, so FilterCycles=1 matches the bypass path.
  always_comb begin
    for (int i = 0; i < Width; i++) begin
      cand_d[i] = cand_q[i];
      cnt_d[i]  = cnt_q[i];
      if (sync2_q[i] != cand_q[i]) begin
        cand_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
      qual[i]   = (cnt_d[i] == CntMax);
      data_d[i] = data_q[i];
      if (!filter_en_i[i] || qual[i]) begin
        data_d[i] = sync2_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q <= '0;
      data_q <= '0;
      prev_q <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cand_q <= cand_d;
      data_q <= data_d;
      prev_q <= data_q;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // sync2 first carries a pad value sampled after reset on the third edge, so capture then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_cnt_q    <= '0;
      strap_q       <= '0;
      strap_valid_q <= 1'b0;
    end else begin
      if (boot_cnt_q != 2'd2) begin
        boot_cnt_q <= boot_cnt_q + 2'd1;
      end
      if (boot_cnt_q == 2'd2 && !strap_valid_q) begin
        strap_q       <= sync2_q[StrapLsb+1:StrapLsb];
        strap_valid_q <= 1'b1;
      end
    end
  end

  assign data_in_o     = data_q;
  assign rise_o        = data_q & ~prev_q;
  assign fall_o        = ~data_q & prev_q;
  assign strap_o       = strap_q;
  assign strap_valid_o = strap_valid_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: directed latency/strap/enable cases plus random pad traffic,
// all checked each cycle against a sample-history model of the conditioning rules.
module tb_gpio_in_cond;
  localparam int W  = 32;
  localparam int FC = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pad = '0;
  logic [W-1:0] en = '0;
  logic [W-1:0] data, rise, fall;
  logic [1:0]   strap;
  logic         sv;

  int checks = 0;
  int errors = 0;

  gpio_in_cond #(.Width(W), .FilterCycles(FC), .StrapLsb(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cio_gpio_p2d_i (pad),
    .filter_en_i    (en),
    .data_in_o      (data),
    .rise_o         (rise),
    .fall_o         (fall),
    .strap_o        (strap),
    .strap_valid_o  (sv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: sync2 is the pad word sampled two edges earlier; a filtered bit follows sync2
  // only once the last FC sync2 samples all agree.
  logic [W-1:0] p_q[$];
  logic [W-1:0] s_q[$];
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_prev = '0;
  logic [1:0]   m_strap = '0;
  logic         m_sv = 1'b0;
  int           m_edges = 0;

  task automatic model_reset();
    p_q.delete();
    s_q.delete();
    m_data  = '0;
    m_prev  = '0;
    m_strap = '0;
    m_sv    = 1'b0;
    m_edges = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] s2, nd;
    logic         stable;
    s2 = (p_q.size() >= 2) ? p_q[p_q.size()-2] : '0;
    p_q.push_back(pad);
    if (p_q.size() > 2) void'(p_q.pop_front());
    s_q.push_back(s2);
    if (s_q.size() > FC) void'(s_q.pop_front());
    nd = m_data;
    for (int i = 0; i < W; i++) begin
      if (!en[i]) begin
        nd[i] = s2[i];
      end else begin
        stable = (s_q.size() == FC);
        for (int j = 0; j < s_q.size(); j++) begin
          if (s_q[j][i] != s2[i]) stable = 1'b0;
        end
        if (stable) nd[i] = s2[i];
      end
    end
    m_prev = m_data;
    m_data = nd;
    if (m_edges < 10) m_edges++;
    if (m_edges == 3) begin
      m_strap = s2[17:16];
      m_sv    = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Scoreboard: every cycle, outputs against the model.
  always @(negedge clk) begin
    check("sb_data", data, m_data);
    check("sb_rise", rise, m_data & ~m_prev);
    check("sb_fall", fall, ~m_data & m_prev);
    check("sb_strap", {30'b0, strap}, {30'b0, m_strap});
    check("sb_strap_valid", {31'b0, sv}, {31'b0, m_sv});
  end

  task automatic measure(input int b, input logic v, output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (data[b] === v) break;
    end
  endtask

  initial begin
    int n;
    logic seen;
    pad[17:16] = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 32'h0);
    check("reset_strap_valid", {31'b0, sv}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straps
    @(posedge clk); @(posedge clk); #1;
    check("strap_valid_edge2", {31'b0, sv}, 32'h0);
    @(posedge clk); #1;
    check("strap_valid_edge3", {31'b0, sv}, 32'h1);
    check("strap_value", {30'b0, strap}, 32'h2);
    @(negedge clk);
    pad[17:16] = 2'b01;
    repeat (6) @(posedge clk);
    #1;
    check("strap_hold", {30'b0, strap}, 32'h2);

    // Unfiltered path on bit 3
    @(negedge clk);
    pad[3] = 1'b1;
    measure(3, 1'b1, n);
    check("unf_rise_latency", n, 32'd3);
    check("unf_rise_pulse", {31'b0, rise[3]}, 32'h1);
    check("unf_rise_nofall", {31'b0, fall[3]}, 32'h0);
    @(posedge clk); #1;
    check("unf_rise_1cycle", {31'b0, rise[3]}, 32'h0);
    @(negedge clk);
    pad[3] = 1'b0;
    measure(3, 1'b0, n);
    check("unf_fall_latency", n, 32'd3);
    check("unf_fall_pulse", {31'b0, fall[3]}, 32'h1);
    check("unf_fall_norise", {31'b0, rise[3]}, 32'h0);
    @(posedge clk); #1;
    check("unf_fall_1cycle", {31'b0, fall[3]}, 32'h0);

    // Filtered path on bit 5: glitch rejected, sustained level passes
    @(negedge clk);
    en[5] = 1'b1;
    repeat (20) @(negedge clk);
    pad[5] = 1'b1;
    repeat (10) @(negedge clk);
    pad[5] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (data[5] || rise[5]) seen = 1'b1;
    end
    check("filt_glitch_blocked", {31'b0, seen}, 32'h0);
    @(negedge clk);
    pad[5] = 1'b1;
    measure(5, 1'b1, n);
    check("filt_latency", n, 32'd18);
    check("filt_rise_pulse", {31'b0, rise[5]}, 32'h1);

    // Filter restart on bit 7
    @(negedge clk);
    en[7] = 1'b1;
    repeat (20) @(negedge clk);
    pad[7] = 1'b1;
    repeat (15) @(negedge clk);
    pad[7] = 1'b0;
    @(negedge clk);
    check("restart_still_low", {31'b0, data[7]}, 32'h0);
    pad[7] = 1'b1;
    measure(7, 1'b1, n);
    check("restart_latency", n, 32'd18);

    // Enable toggle on bit 2
    @(negedge clk);
    en[2]  = 1'b1;
    pad[2] = 1'b1;
    repeat (25) @(negedge clk);
    check("toggle_qualified_high", {31'b0, data[2]}, 32'h1);
    pad[2] = 1'b0;
    repeat (5) @(negedge clk);
    check("toggle_held_high", {31'b0, data[2]}, 32'h1);
    en[2] = 1'b0;
    @(posedge clk); #1;
    check("toggle_drop", {31'b0, data[2]}, 32'h0);
    check("toggle_fall_pulse", {31'b0, fall[2]}, 32'h1);
    @(posedge clk); #1;
    check("toggle_fall_1cycle", {31'b0, fall[2]}, 32'h0);

    // Random traffic with an asynchronous reset in the middle
    @(negedge clk);
    en = $urandom();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 19) == 0) pad[i] = ~pad[i];
      end
      if ($urandom_range(0, 49) == 0) en = $urandom();
      if (c == 700) begin
        en = '1;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 32'h0);
        check("midrst_rise", rise, 32'h0);
        check("midrst_fall", fall, 32'h0);
        check("midrst_strap", {30'b0, strap}, 32'h0);
        check("midrst_strap_valid", {31'b0, sv}, 32'h0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
